led_pio_blink: RTL and testbench

Parametrised Avalon-MM output PIO driving up to 32 LEDs, the successor to the fixed 10-bit LED port in the TimerWithClock system. Adds atomic set/clear/toggle registers and a per-bit hardware blink mode timed by an internal programmable prescaler, so the Nios II software can flash alarm/status LEDs without polling. Sits on the system interconnect as a zero-wait-state slave; `out_port` goes straight to board LED pins.

---
 rtl/led_pio_pkg.sv | 25 ++
 rtl/led_blink_timer.sv | 44 ++++
 rtl/led_pio_blink.sv | 123 ++++++++++++
 tb/tb_led_pio_blink.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO with hardware blink.
//   - Word offsets of the Avalon-MM register map.
//   - Bit position of the blink phase inside STATUS.
//   - Decoded bus request struct used by the top-level register file.
package led_pio_pkg;

  localparam logic [2:0] LED_REG_DATA      = 3'd0;  // RW
  localparam logic [2:0] LED_REG_BLINK_EN  = 3'd1;  // RW
  localparam logic [2:0] LED_REG_PERIOD    = 3'd2;  // RW, CNT_W bits
  localparam logic [2:0] LED_REG_OUTSET    = 3'd3;  // WO, DATA |= wd
  localparam logic [2:0] LED_REG_OUTCLR    = 3'd4;  // WO, DATA &= ~wd
  localparam logic [2:0] LED_REG_OUTTOGGLE = 3'd5;  // WO, DATA ^= wd
  localparam logic [2:0] LED_REG_STATUS    = 3'd6;  // RO
  localparam logic [2:0] LED_REG_RSVD      = 3'd7;  // reads 0

  localparam int LED_STATUS_PHASE_BIT = 0;

  // One bus beat after write qualification.
  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } led_bus_req_t;

endpackage

// File: rtl/led_blink_timer.sv
// Blink prescaler shared by all LEDs.
//   clk, reset     : system clock, asynchronous active-high reset
//   period         : half-period in clocks; during a period write this is
//                    the value being written, otherwise the live register
//   period_wr      : a write to BLINK_PERIOD lands on this edge
//   phase          : blink phase, 1 = blinking LEDs lit
// cnt runs 0..period-1; at the terminal count it wraps and phase inverts.
// period == 0 parks cnt at 0 and freezes phase.
module led_blink_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             period_wr,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;
  logic             term;

  assign term = (cnt == period - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (period_wr) begin
      // A period write restarts the half-period and wins over a terminal
      // count on the same edge. Writing 0 is the "freeze" request: the
      // LEDs hold whatever phase they are showing, so phase is left alone.
      cnt <= '0;
      if (period != '0) phase <= 1'b1;
    end else if (period == '0) begin
      cnt <= '0;
    end else if (term) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM output PIO for up to 32 LEDs with atomic set/clear/toggle and
// per-bit hardware blink. Zero-wait-state slave.
//   clk, reset   : system clock, asynchronous active-high reset
//   address      : word register index (see led_pio_pkg)
//   chipselect   : slave select
//   write_n      : active-low write strobe, qualified by chipselect
//   writedata    : write data; bits above WIDTH / CNT_W are ignored
//   readdata     : combinational read of the addressed register, zero-extended
//   out_port     : LED drive, DATA masked by blink phase on BLINK_EN bits
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int               WIDTH        = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               CNT_W        = 32,
  parameter logic [31:0]      PERIOD_RESET = 32'd25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [CNT_W-1:0] PERIOD_RST = PERIOD_RESET[CNT_W-1:0];

  led_bus_req_t     req;
  logic [WIDTH-1:0] wd;
  logic [CNT_W-1:0] period_wd;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] blink_en_q;
  logic [CNT_W-1:0] period_q;

  logic             period_wr;
  logic [CNT_W-1:0] period_nxt;
  logic             phase;

  // Upper writedata bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign req = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};
  assign wd        = req.wdata[WIDTH-1:0];
  assign period_wd = req.wdata[CNT_W-1:0];

  // ---------------------------------------------------------------------
  // Register file. Only one offset is written per cycle, so the atomic
  // set/clear/toggle forms never collide with a plain DATA write.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (req.wr) begin
      case (req.addr)
        LED_REG_DATA:      data_q <= wd;
        LED_REG_OUTSET:    data_q <= data_q | wd;
        LED_REG_OUTCLR:    data_q <= data_q & ~wd;
        LED_REG_OUTTOGGLE: data_q <= data_q ^ wd;
        default:           data_q <= data_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_en_q <= '0;
    end else if (req.wr && req.addr == LED_REG_BLINK_EN) begin
      blink_en_q <= wd;
    end
  end

  assign period_wr = req.wr && (req.addr == LED_REG_PERIOD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= PERIOD_RST;
    end else if (period_wr) begin
      period_q <= period_wd;
    end
  end

  // The timer needs the incoming period on the write edge to tell a
  // freeze (0) from a restart.
  assign period_nxt = period_wr ? period_wd : period_q;

  led_blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .period    (period_nxt),
    .period_wr (period_wr),
    .phase     (phase)
  );

  // ---------------------------------------------------------------------
  // Read mux: pure function of address and flops, so during a write cycle
  // it shows the pre-write contents.
  // ---------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      LED_REG_DATA:     readdata[WIDTH-1:0] = data_q;
      LED_REG_BLINK_EN: readdata[WIDTH-1:0] = blink_en_q;
      LED_REG_PERIOD:   readdata[CNT_W-1:0] = period_q;
      LED_REG_STATUS:   readdata[LED_STATUS_PHASE_BIT] = phase;
      default:          readdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output mask: blinking bits follow phase, steady bits follow DATA.
  // Built only from flops, so no bus input reaches the pins combinationally.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign out_port[i] = data_q[i] & (~blink_en_q[i] | phase);
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Self-checking bench for led_pio_blink: directed register-map and blink
// scenarios followed by randomized bus traffic, all compared against a
// time-based reference model (phase derived from elapsed clocks since the
// last restart divided by the half-period).
module tb_led_pio_blink;

  localparam int          W  = 10;
  localparam logic [W-1:0] RV = 10'h2A5;
  localparam int          CW = 32;
  localparam logic [31:0] PR = 32'd25_000_000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  always #5 clk = ~clk;

  led_pio_blink #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .CNT_W        (CW),
    .PERIOD_RESET (PR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_data, m_en;
  logic [31:0]  m_per;
  logic         m_ph0;     // phase at the last restart
  longint       m_n;       // clock edges seen out of reset
  longint       m_t0;      // edge count at the last restart

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_phase();
    longint halves;
    if (m_per == 0) return m_ph0;
    halves = (m_n - m_t0) / longint'({32'b0, m_per});
    return m_ph0 ^ ((halves % 2) == 1);
  endfunction

  function automatic logic [W-1:0] m_out();
    return m_data & (~m_en | {W{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_en);
      3'd2: return m_per;
      3'd6: return {31'b0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = RV; m_en = '0; m_per = PR; m_ph0 = 1'b1; m_t0 = m_n;
  endtask

  task automatic model_edge(input logic wr, input logic [2:0] a, input logic [31:0] d);
    logic p;
    p = m_phase();
    m_n++;
    if (wr) begin
      case (a)
        3'd0: m_data = d[W-1:0];
        3'd1: m_en   = d[W-1:0];
        3'd2: begin
          m_per = d; m_t0 = m_n;
          m_ph0 = (d != 0) ? 1'b1 : p;
        end
        3'd3: m_data = m_data | d[W-1:0];
        3'd4: m_data = m_data & ~d[W-1:0];
        3'd5: m_data = m_data ^ d[W-1:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: starts just after a posedge, samples at the negedge,
  // ends just after the next posedge.
  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
    chipselect = cs; write_n = wn; address = a; writedata = d;
    @(negedge clk);
    rd = readdata;
    chk("readdata", readdata, m_read(a));
    chk("out_port", 32'(out_port), 32'(m_out()));
    @(posedge clk);
    model_edge(cs && !wn, a, d);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] v;
    cycle(1'b1, 1'b0, a, d, v);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    cycle(1'b1, 1'b1, a, 32'h0, v);
  endtask

  task automatic idle(input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 3'd6, $urandom, v);
  endtask

  // Reset pulse between clock edges; no edge is seen while asserted.
  task automatic pulse_reset();
    chipselect = 1'b0; write_n = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("reset_out_port", 32'(out_port), 32'(RV));
    @(negedge clk);
    chk("reset_status", readdata, m_read(address));
    reset = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 3'd0, 32'h0);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0]  a;
    logic [31:0] d;
    logic        cs, wn;

    m_n = 0;
    model_reset();
    #12;
    chk("por_out_port", 32'(out_port), 32'(RV));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 3'd0, 32'h0);
    #1;

    // Reset values
    rd(3'd0, v); chk("rst_data", v, 32'h2A5);
    rd(3'd1, v); chk("rst_blink_en", v, 32'h0);
    rd(3'd2, v); chk("rst_period", v, PR);
    rd(3'd6, v); chk("rst_status", v, 32'h1);

    // Atomic set / clear / toggle
    wr(3'd0, 32'h0F0); rd(3'd0, v); chk("data_wr", v, 32'h0F0);
    wr(3'd3, 32'h00F); rd(3'd0, v); chk("outset", v, 32'h0FF);
    wr(3'd4, 32'h030); rd(3'd0, v); chk("outclr", v, 32'h0CF);
    wr(3'd5, 32'h300); rd(3'd0, v); chk("outtoggle", v, 32'h3CF);
    rd(3'd3, v); chk("rd_outset_zero", v, 32'h0);
    rd(3'd4, v); chk("rd_outclr_zero", v, 32'h0);
    rd(3'd5, v); chk("rd_outtoggle_zero", v, 32'h0);

    // Upper bits ignored, reserved reads 0
    wr(3'd0, 32'hFFFF_FFFF); rd(3'd0, v); chk("data_width_trunc", v, 32'h3FF);
    rd(3'd7, v); chk("rd_reserved_zero", v, 32'h0);

    // Blink: period 4, bit0 blinking, bit1 steady
    wr(3'd2, 32'd4); wr(3'd0, 32'h003); wr(3'd1, 32'h001);
    idle(16);

    // Freeze: wait for phase 0 then write period 0
    for (int i = 0; i < 8 && m_phase(); i++) idle(1);
    chk("phase_low_before_freeze", 32'(m_phase()), 32'h0);
    wr(3'd2, 32'd0);
    idle(10);
    rd(3'd6, v); chk("frozen_status", v, 32'h0);
    chk("frozen_bit0", 32'(out_port[0]), 32'h0);
    wr(3'd2, 32'd3);
    rd(3'd6, v); chk("restart_phase_hi", v, 32'h1);
    idle(2);
    rd(3'd6, v); chk("restart_phase_inv", v, 32'h0);

    // Reset mid-blink at phase 0, cnt 2
    wr(3'd2, 32'd4);
    idle(6);
    chk("pre_reset_phase", 32'(m_phase()), 32'h0);
    pulse_reset();
    rd(3'd2, v); chk("post_reset_period", v, PR);
    rd(3'd6, v); chk("post_reset_status", v, 32'h1);
    chk("post_reset_out", 32'(out_port), 32'h2A5);

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end else begin
        a  = 3'($urandom_range(0, 7));
        cs = ($urandom_range(0, 3) != 0);
        wn = 1'($urandom_range(0, 1));
        d  = $urandom;
        if (a == 3'd2) d = $urandom_range(0, 7);
        cycle(cs, wn, a, d, v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
